// File: rtl/rr_fanout_pkg.sv
// Shared types and the round-robin lane search for rr_fanout_dispatch.
//   lane_t / word_t : lane index and payload types at the default sizes
//   lane_pick_t     : {found, sel} result of a lane search
//   next_lane()     : first free lane scanning ptr, ptr+1, ... mod n
package rr_fanout_pkg;

  localparam int unsigned NUM_LANES_DEF = 5;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned MAX_LANES     = 8;
  localparam int unsigned LANE_W_DEF    = $clog2(NUM_LANES_DEF);

  typedef logic [LANE_W_DEF-1:0] lane_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  typedef struct packed {
    logic       found;
    logic [2:0] sel;
  } lane_pick_t;

  // free_mask bits at or above n must be zero; n is 2..MAX_LANES.
  function automatic lane_pick_t next_lane(input logic [2:0]           ptr,
                                           input logic [MAX_LANES-1:0] free_mask,
                                           input int unsigned          n);
    lane_pick_t  pick;
    int unsigned idx;
    logic [2:0]  idx3;
    pick = '0;
    for (int unsigned k = 0; k < MAX_LANES; k++) begin
      idx  = (32'(ptr) + k) % n;
      idx3 = idx[2:0];
      if (k < n && !pick.found && free_mask[idx3]) begin
        pick.found = 1'b1;
        pick.sel   = idx3;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_fanout_dispatch_sync_fifo.sv
// Synchronous FIFO, DEPTH x DATA_W, head word visible on rdata_o.
//   push_i/pop_i : write tail / retire head (caller never overflows/underflows)
//   full_o/empty_o/count_o : occupancy status from registered state
module sync_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [PTR_W:0]    cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_W'(1);
      if (pop_i)  rd_q <= rd_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; a word is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= (PTR_W+1)'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    pop_i |-> !empty_o);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push_i |-> !full_o);

endmodule

// File: rtl/rr_fanout_dispatch.sv
// Round-robin fan-out of one valid/ready stream to NUM_LANES registered slots.
//   in_valid/in_ready/in_data     : upstream stream into an input FIFO
//   out_valid/out_ready/out_data  : one registered slot per lane
//   fifo_count, dispatch_count, last_lane : observation status
module rr_fanout_dispatch
  import rr_fanout_pkg::*;
#(
  parameter int unsigned NUM_LANES = 5,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic [NUM_LANES-1:0]          out_valid,
  input  logic [NUM_LANES-1:0]          out_ready,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic [CNT_W-1:0]              dispatch_count,
  output logic [$clog2(NUM_LANES)-1:0]  last_lane
);

  localparam int unsigned LANE_W = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0] slot_vld_q, slot_vld_d;
  logic [DATA_W-1:0]    slot_dat_q [NUM_LANES];
  logic [DATA_W-1:0]    slot_dat_d [NUM_LANES];
  logic [LANE_W-1:0]    rr_q, rr_d, last_q, last_d, sel;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 alive_q;

  logic                 push, pop, full, empty;
  logic [DATA_W-1:0]    head;
  logic [NUM_LANES-1:0] hs, free;
  logic [MAX_LANES-1:0] free_ext;
  lane_pick_t           pick;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_data),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  // alive_q holds in_ready low through reset and for the release cycle.
  assign in_ready = alive_q & ~full;
  assign push     = in_valid & in_ready;

  always_comb begin
    hs         = slot_vld_q & out_ready;
    free       = ~slot_vld_q | out_ready;
    free_ext   = '0;
    free_ext[NUM_LANES-1:0] = free;
    pick       = next_lane(3'(rr_q), free_ext, NUM_LANES);
    sel        = LANE_W'(pick.sel);
    pop        = pick.found & ~empty;

    slot_vld_d = slot_vld_q & ~hs;
    slot_dat_d = slot_dat_q;
    rr_d       = rr_q;
    last_d     = last_q;
    cnt_d      = cnt_q;

    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (hs[i]) cnt_d = cnt_d + CNT_W'(1);
    end

    // A lane handshaking this cycle counts as free, so it may be refilled.
    if (pop) begin
      slot_vld_d[sel] = 1'b1;
      slot_dat_d[sel] = head;
      last_d          = sel;
      rr_d            = (sel == LANE_W'(NUM_LANES-1)) ? '0 : sel + LANE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) slot_dat_q[i] <= '0;
      rr_q    <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_dat_q <= slot_dat_d;
      rr_q       <= rr_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      alive_q    <= 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      out_data[i*DATA_W +: DATA_W] = slot_dat_q[i];
    end
  end

  assign out_valid      = slot_vld_q;
  assign dispatch_count = cnt_q;
  assign last_lane      = last_q;

endmodule

// File: tb/tb_rr_fanout_dispatch.sv
module tb_rr_fanout_dispatch;

  localparam int N     = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = '0;
  logic [4:0]    out_valid;
  logic [4:0]    out_ready = '0;
  logic [39:0]   out_data;
  logic [2:0]    fifo_count;
  logic [15:0]   dispatch_count;
  logic [2:0]    last_lane;

  int checks = 0;
  int errors = 0;

  rr_fanout_dispatch #(
    .NUM_LANES (N),
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .CNT_W     (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .fifo_count     (fifo_count),
    .dispatch_count (dispatch_count),
    .last_lane      (last_lane)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue for the FIFO, one slot per lane, a scan pointer.
  logic [7:0] m_q[$];
  bit         m_v [N];
  logic [7:0] m_d [N] = '{default: 8'h00};
  int         m_rr = 0;
  int         m_last = 0;
  int         m_dc = 0;
  bit         m_alive = 0;

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      m_q.delete();
      for (int i = 0; i < N; i++) begin m_v[i] = 0; m_d[i] = 8'h00; end
      m_rr = 0; m_last = 0; m_dc = 0; m_alive = 0;
    end else begin
      bit rdy;
      int sel;
      rdy = m_alive && (m_q.size() < DEPTH);
      sel = -1;
      if (m_q.size() > 0) begin
        for (int k = 0; k < N; k++) begin
          int ln;
          ln = (m_rr + k) % N;
          if (sel < 0 && (!m_v[ln] || out_ready[ln])) sel = ln;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (m_v[i] && out_ready[i]) begin
          m_v[i] = 0;
          m_dc = (m_dc + 1) % 65536;
        end
      end
      if (sel >= 0) begin
        m_d[sel] = m_q.pop_front();
        m_v[sel] = 1;
        m_last = sel;
        m_rr = (sel + 1) % N;
      end
      if (in_valid && rdy) m_q.push_back(in_data);
      m_alive = 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic [4:0] ev;
    for (int i = 0; i < N; i++) ev[i] = m_v[i];
    check("in_ready", in_ready, m_alive && (m_q.size() < DEPTH));
    check("out_valid", out_valid, ev);
    check("fifo_count", fifo_count, m_q.size());
    check("dispatch_count", dispatch_count, m_dc);
    check("last_lane", last_lane, m_last);
    for (int i = 0; i < N; i++)
      check($sformatf("out_data[%0d]", i), out_data[i*DW +: DW], m_d[i]);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [7:0] d);
    bit acc;
    acc = 0;
    in_valid = 1'b1;
    in_data = d;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = m_alive && (m_q.size() < DEPTH);
      step();
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout: actual not accepted required accepted (data %0h)", d);
    end
  endtask

  initial begin
    // Basic round robin with all lanes ready.
    do_reset();
    check("reset_dc", dispatch_count, 16'h0000);
    check("reset_in_ready", in_ready, 1'b1);
    out_ready = 5'h1f;
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    repeat (3) step();
    check("t1_dc", dispatch_count, 16'd5);
    check("t1_last", last_lane, 3'd4);
    for (int i = 0; i < N; i++)
      check("t1_lane_data", out_data[i*DW +: DW], 8'(8'h10 + i));
    push(8'h15);
    step();
    check("t1_wrap_lane0", last_lane, 3'd0);
    check("t1_wrap_data", out_data[7:0], 8'h15);

    // All lanes stalled: slots fill, FIFO fills, word 10 waits.
    do_reset();
    out_ready = '0;
    for (int i = 1; i <= 9; i++) push(8'(i));
    check("t2_fifo_full", fifo_count, 3'd4);
    check("t2_in_ready", in_ready, 1'b0);
    check("t2_out_valid", out_valid, 5'h1f);
    check("t2_lane4", out_data[39:32], 8'd5);
    in_valid = 1'b1;
    in_data = 8'd10;
    repeat (3) step();
    check("t2_held_ready", in_ready, 1'b0);
    check("t2_held_count", fifo_count, 3'd4);
    out_ready = 5'b00001;
    step();
    out_ready = '0;
    check("t4_pop_no_push", fifo_count, 3'd3);
    check("t4_ready_back", in_ready, 1'b1);
    check("t4_lane0_w6", out_data[7:0], 8'd6);
    step();
    in_valid = 1'b0;
    check("t4_refill", fifo_count, 3'd4);

    // Lane 2 stalled with a word in it; it is skipped.
    do_reset();
    out_ready = 5'b11011;
    for (int i = 0; i < 10; i++) push(8'(8'h20 + i));
    repeat (4) step();
    check("t3_lane2_valid", out_valid[2], 1'b1);
    check("t3_lane2_data", out_data[23:16], 8'h22);
    check("t3_last", last_lane, 3'd0);
    check("t3_lane3", out_data[31:24], 8'h27);
    check("t3_lane1", out_data[15:8], 8'h26);

    // Dispatch counter wrap, then a 3-lane handshake cycle.
    do_reset();
    out_ready = 5'h1f;
    in_valid = 1'b1;
    for (int n = 0; n < 70000 && m_dc != 65535; n++) begin
      in_data = 8'($urandom);
      step();
    end
    if (m_dc != 65535) begin
      checks++; errors++;
      $display("FAIL wrap_timeout: actual %0d required 65535", m_dc);
    end
    check("t5_ffff", dispatch_count, 16'hFFFF);
    step();
    check("t5_wrap0", dispatch_count, 16'h0000);
    out_ready = '0;
    repeat (8) step();
    begin
      int e;
      e = (m_dc + 3) % 65536;
      out_ready = 5'b00111;
      step();
      out_ready = '0;
      check("t5_plus3", dispatch_count, 16'(e));
    end
    in_valid = 1'b0;

    // Asynchronous reset with full slots and a partly filled FIFO.
    do_reset();
    out_ready = 5'h1f;
    push(8'hB0);
    push(8'hB1);
    repeat (3) step();
    out_ready = '0;
    for (int i = 0; i < 7; i++) push(8'(8'hC0 + i));
    check("t6_pre_count", fifo_count, 3'd2);
    check("t6_pre_dc", dispatch_count, 16'd2);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 5'h00);
    check("t6_async_count", fifo_count, 3'd0);
    check("t6_async_dc", dispatch_count, 16'h0000);
    check("t6_async_ready", in_ready, 1'b0);
    do_reset();
    out_ready = 5'h1f;
    push(8'hA5);
    step();
    check("t6_first_lane", last_lane, 3'd0);
    check("t6_first_valid", out_valid, 5'b00001);
    check("t6_first_data", out_data[7:0], 8'hA5);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      out_ready = 5'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
